// File: rtl/vga_capture_pkg.sv
// vga_capture_pkg: shared constants and types for the VGA frame capture block.
//   - default video timing (back porch / visible extents)
//   - capture FIFO depth, address and counter widths
//   - capture state encoding
//   - rgb332(): packs the sampled colour into the stored byte
package vga_capture_pkg;

  localparam int H_BP_DEF   = 48;
  localparam int H_VIS_DEF  = 640;
  localparam int V_BP_DEF   = 33;
  localparam int V_VIS_DEF  = 480;

  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 21;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_FRAME,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Stored byte is RGB332: the blue LSB is discarded by the caller.
  function automatic logic [DATA_W-1:0] rgb332(input logic [2:0] r,
                                               input logic [2:0] g,
                                               input logic [1:0] b_hi);
    return {r, g, b_hi};
  endfunction

endpackage

// File: rtl/vga_capture_if.sv
// vga_capture_if: memory write port of the capture block.
//   addr   : write address
//   wd     : write data
//   we     : write request
//   wready : memory accepts the write this cycle when we=1
// master = capture block, slave = memory.
interface vga_capture_if;
  import vga_capture_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wd;
  logic              we;
  logic              wready;

  modport master (output addr, wd, we, input wready);
  modport slave  (input addr, wd, we, output wready);
endinterface

// File: rtl/vga_capture_capfifo.sv
// capfifo: small synchronous FIFO between pixel capture and memory writes.
//   clk, resetq : clock, async active-low reset (empties FIFO, clears storage)
//   push, din   : write; ignored when full
//   pop         : read; ignored when empty
//   dout        : head entry (0 after reset)
//   full, empty : occupancy flags
// A simultaneous push and pop leaves the occupancy unchanged.
module capfifo
  import vga_capture_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = DATA_W
) (
  input  logic         clk,
  input  logic         resetq,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wp_q, rp_q;
  logic [PW:0]             cnt_q;
  logic                    do_push, do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rp_q];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din;
        wp_q        <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/vga_capture.sv
// vga_capture: captures one full VGA frame into memory as RGB332 bytes.
//   clk, resetq          : clock, async active-low reset
//   pix                  : pixel strobe; video inputs only sampled when pix=1
//   arm                  : pulse in IDLE/DONE to capture the next full frame
//   vga_red/green/blue   : pixel colour
//   vga_hsync_n/vsync_n  : active-low syncs
//   mem (master)         : addr/wd/we out, wready in
//   busy                 : SYNC, FRAME or FLUSH
//   done                 : sticky, frame fully written
//   overflow             : sticky, pixel dropped or vsync seen mid-frame
// Timing is counted from sync rising edges: the hsync-rise strobe has
// hcount 0, every other strobe increments it; each hsync rise bumps lcount.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_BP  = H_BP_DEF,
  parameter int H_VIS = H_VIS_DEF,
  parameter int V_BP  = V_BP_DEF,
  parameter int V_VIS = V_VIS_DEF
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       pix,
  input  logic       arm,
  input  logic [2:0] vga_red,
  input  logic [2:0] vga_green,
  input  logic [2:0] vga_blue,
  input  logic       vga_hsync_n,
  input  logic       vga_vsync_n,
  vga_capture_if.master mem,
  output logic       busy,
  output logic       done,
  output logic       overflow
);
  localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_BP);
  localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_BP + H_VIS);
  localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_BP);
  localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_BP + V_VIS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d, ovf_q, ovf_d;
  logic              hs_prev_q, vs_prev_q;
  logic              hs_rise, vs_rise;
  logic              push, pop, full, empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              unused_blue_lsb;

  // Blue LSB is dropped by the RGB332 packing.
  assign unused_blue_lsb = vga_blue[0];

  assign hs_rise = pix & ~hs_prev_q & vga_hsync_n;
  assign vs_rise = pix & ~vs_prev_q & vga_vsync_n;

  assign mem.we   = ~empty;
  assign mem.wd   = fifo_dout;
  assign mem.addr = addr_q;
  assign pop      = mem.we & mem.wready;

  assign busy     = (state_q == ST_SYNC) || (state_q == ST_FRAME) ||
                    (state_q == ST_FLUSH);
  assign done     = done_q;
  assign overflow = ovf_q;

  capfifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (push),
    .pop    (pop),
    .din    (rgb332(vga_red, vga_green, vga_blue[2:1])),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty)
  );

  // Previous sync samples, only advanced on pixel strobes.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
    end else if (pix) begin
      hs_prev_q <= vga_hsync_n;
      vs_prev_q <= vga_vsync_n;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      lcnt_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      lcnt_q  <= lcnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    addr_d  = addr_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    push    = 1'b0;

    // Address wraps naturally at 2^ADDR_W.
    if (pop) addr_d = addr_q + 1'b1;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          addr_d  = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (vs_rise) begin
          lcnt_d  = '0;
          state_d = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (pix) begin
          if (hs_rise) begin
            hcnt_d = '0;
            lcnt_d = lcnt_q + 1'b1;
          end else if (hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + 1'b1;
          end
          // Unexpected vsync: restart the line count, keep writing on.
          if (vs_rise) begin
            lcnt_d = '0;
            ovf_d  = 1'b1;
          end
          // Window test uses this strobe's updated counters.
          if (lcnt_d == V_HI) begin
            state_d = ST_FLUSH;
          end else if (lcnt_d >= V_LO && lcnt_d < V_HI &&
                       hcnt_d >= H_LO && hcnt_d < H_HI) begin
            if (full) ovf_d = 1'b1;
            else      push  = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled-down frame (16 strobes x 9 lines,
// 8x4 visible), pixel strobe every 5 clocks. Expected bytes go into a
// queue as the frame generator drives visible pixels; the write monitor
// pops and compares them together with the running address.
module tb_vga_capture;
  import vga_capture_pkg::*;

  localparam int H_BP  = 3;
  localparam int H_VIS = 8;
  localparam int V_BP  = 2;
  localparam int V_VIS = 4;
  localparam int HS_W  = 2;   // hsync low strobes at start of each line
  localparam int H_TOT = 16;
  localparam int VS_W  = 2;   // vsync low lines at start of frame
  localparam int V_TOT = 9;
  localparam int NPIX  = H_VIS * V_VIS;

  logic       clk = 1'b0;
  logic       resetq, pix, arm;
  logic [2:0] vga_red, vga_green, vga_blue;
  logic       vga_hsync_n, vga_vsync_n;
  logic       busy, done, overflow;

  vga_capture_if m();

  vga_capture #(.H_BP(H_BP), .H_VIS(H_VIS), .V_BP(V_BP), .V_VIS(V_VIS)) dut (
    .clk         (clk),
    .resetq      (resetq),
    .pix         (pix),
    .arm         (arm),
    .vga_red     (vga_red),
    .vga_green   (vga_green),
    .vga_blue    (vga_blue),
    .vga_hsync_n (vga_hsync_n),
    .vga_vsync_n (vga_vsync_n),
    .mem         (m),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, stall_lo = 0, stall_hi = 0;
  logic wr_toggle = 1'b0;
  logic sb_en = 1'b0;
  logic [7:0] sbq[$];
  int wr_total = 0, wr_base = 0, wr_snap = 0;
  int done_rises = 0, rises_base = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  assign m.wready = wr_toggle ? cyc[0] : !(cyc >= stall_lo && cyc < stall_hi);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: address follows the write count since arm, data from queue.
  always @(negedge clk) begin
    if (resetq && m.we && m.wready) begin
      chk("wr_addr", 32'(m.addr), 32'(wr_total - wr_base));
      if (sb_en) begin
        if (sbq.size() == 0) chk("sb_has_entry", 32'(sbq.size()), 32'd1);
        else                 chk("wr_data", 32'(m.wd), 32'(sbq.pop_front()));
      end
      wr_total++;
    end
  end

  always @(negedge clk) begin
    if (done && !done_prev) done_rises++;
    done_prev = done;
  end

  task automatic strobe(input logic hs, input logic vs, input logic [8:0] rgb);
    vga_hsync_n = hs;
    vga_vsync_n = vs;
    {vga_red, vga_green, vga_blue} = rgb;
    pix = 1'b1;
    @(posedge clk); #1;
    pix = 1'b0;
    arm = 1'b0;
    // Junk between strobes must be ignored.
    vga_hsync_n = 1'($urandom);
    vga_vsync_n = 1'($urandom);
    {vga_red, vga_green, vga_blue} = 9'($urandom);
  endtask

  task automatic gap();
    repeat (4) begin
      @(posedge clk); #1;
      arm = 1'b0;
    end
  endtask

  task automatic do_arm();
    wr_base    = wr_total;
    rises_base = done_rises;
    arm = 1'b1;
    strobe(1'b1, 1'b1, 9'($urandom));
    gap();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_set", 32'(done), 32'd1);
  endtask

  // mode 0 plain, 1 wready stall, 2 reset mid-frame, 3 re-arm mid-frame
  task automatic frame(input logic [7:0] seed, input int mode);
    for (int l = 0; l < V_TOT; l++) begin
      for (int s = 0; s < H_TOT; s++) begin
        int hc, lc, x, y;
        logic vis;
        logic [7:0] v;
        logic [8:0] rgb;
        hc  = s - HS_W;
        lc  = l - VS_W + 1;
        vis = (l >= VS_W) && (s >= HS_W) && (lc >= V_BP) && (lc < V_BP + V_VIS) &&
              (hc >= H_BP) && (hc < H_BP + H_VIS);
        x = hc - H_BP;
        y = lc - V_BP;
        v = 8'(x + y) + seed;
        rgb = vis ? {v, 1'($urandom)} : 9'($urandom);
        if (vis && sb_en) sbq.push_back(v);
        strobe(s >= HS_W, l >= VS_W, rgb);
        if (vis && x == 0 && y == 0) chk("latency_we", 32'(m.we), 32'd1);
        if (vis && y == 1 && x == 0 && mode == 1) begin
          stall_lo = cyc;
          stall_hi = cyc + 40;
        end
        if (vis && y == 1 && x == 0 && mode == 3) begin
          chk("busy_mid", 32'(busy), 32'd1);
          arm = 1'b1;
        end
        if (vis && y == 2 && x == 0 && mode == 3) chk("done_mid", 32'(done), 32'd0);
        if (vis && y == 1 && x == 2 && mode == 2) begin
          chk("pre_rst_we", 32'(m.we), 32'd1);
          resetq = 1'b0;
          #1;
          chk("rst_we", 32'(m.we), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          chk("rst_addr", 32'(m.addr), 32'd0);
          chk("rst_done", 32'(done), 32'd0);
          sb_en   = 1'b0;
          wr_snap = wr_total;
          @(negedge clk);
          resetq = 1'b1;
        end
        gap();
      end
    end
  endtask

  initial begin
    resetq = 1'b0; pix = 1'b0; arm = 1'b0;
    vga_hsync_n = 1'b1; vga_vsync_n = 1'b1;
    {vga_red, vga_green, vga_blue} = '0;
    @(negedge clk);
    chk("reset_we", 32'(m.we), 32'd0);
    chk("reset_wd", 32'(m.wd), 32'd0);
    chk("reset_addr", 32'(m.addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    resetq = 1'b1;
    @(posedge clk); #1;

    // Frame A: wready always high, byte = x+y.
    sb_en = 1'b1;
    do_arm();
    chk("armed_busy", 32'(busy), 32'd1);
    frame(8'h00, 0);
    wait_done();
    chk("a_busy", 32'(busy), 32'd0);
    chk("a_ovf", 32'(overflow), 32'd0);
    chk("a_writes", 32'(wr_total - wr_base), 32'(NPIX));
    chk("a_addr_end", 32'(m.addr), 32'(NPIX));
    chk("a_sb_drained", 32'(sbq.size()), 32'd0);

    // Frame B: wready toggling, extra arm mid-frame.
    wr_toggle = 1'b1;
    do_arm();
    frame(8'hB5, 3);
    wait_done();
    wr_toggle = 1'b0;
    chk("b_ovf", 32'(overflow), 32'd0);
    chk("b_writes", 32'(wr_total - wr_base), 32'(NPIX));
    chk("b_done_once", 32'(done_rises - rises_base), 32'd1);
    chk("b_sb_drained", 32'(sbq.size()), 32'd0);

    // Frame C: 40-clock wready stall mid-line overruns the FIFO.
    sb_en = 1'b0;
    do_arm();
    frame(8'h11, 1);
    wait_done();
    chk("c_ovf", 32'(overflow), 32'd1);
    chk("c_fewer_writes", 32'((wr_total - wr_base) < NPIX), 32'd1);

    // Frame D: reset pulse mid-frame, then no arm.
    sb_en = 1'b1;
    do_arm();
    frame(8'h3C, 2);
    repeat (20) @(posedge clk);
    #1;
    chk("d_no_writes", 32'(wr_total - wr_snap), 32'd0);
    chk("d_busy", 32'(busy), 32'd0);

    // Zero-width frame: vsync toggles, hsync never falls.
    sb_en = 1'b0;
    do_arm();
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 20; k++) begin
        strobe(1'b1, k >= 10, 9'($urandom));
        gap();
      end
    end
    chk("z_busy", 32'(busy), 32'd1);
    chk("z_done", 32'(done), 32'd0);
    chk("z_we", 32'(m.we), 32'd0);
    chk("z_writes", 32'(wr_total - wr_base), 32'd0);
    chk("z_ovf", 32'(overflow), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
